// File: rtl/cpu8_pkg.sv
// rtl/cpu8_pkg.sv - Shared encodings and widths for the 8-bit CPU memory path
package cpu8_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// rtl/mem_port_arbiter_arb2_rr.sv - Two-way fetch/data arbiter, fixed-priority or round-robin
module arb2_rr
  import cpu8_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       prio_mode_i,
  input  logic       upd_i,
  output logic [1:0] win_o
);

  owner_e ptr_q;
  owner_e ptr_d;

  // req_i[0] is fetch, req_i[1] is data; ptr_q names the preferred requester on a tie.
  always_comb begin
    win_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = (prio_mode_i || ptr_q == OWN_DATA) ? 2'b10 : 2'b01;
      default: win_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && win_o != 2'b00) begin
      ptr_d = win_o[1] ? OWN_FETCH : OWN_DATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= OWN_FETCH;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one RAM port between instruction fetch and data load/store
module mem_port_arbiter #(
  parameter int ADDR_W    = cpu8_pkg::ADDR_W,
  parameter int DATA_W    = cpu8_pkg::DATA_W,
  parameter int RD_LAT    = 1,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_csel,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  import cpu8_pkg::*;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..3");
  end

  state_e            state_q;
  owner_e            owner_q;
  logic [1:0]        cnt_q;
  logic              f_gnt_q, d_gnt_q, f_valid_q, d_valid_q;
  logic              ram_csel_q, ram_read_q, busy_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, f_rdata_q, d_rdata_q;
  logic [1:0]        win;
  logic              grant;
  logic              rd_done;

  assign grant = (state_q == ST_IDLE) && (win != 2'b00);

  // Read data is sampled on the edge that ends its RAM latency; that edge also enters RESP.
  assign rd_done = ram_read_q &&
                   ((state_q == ST_ISSUE && RD_LAT == 1) ||
                    (state_q == ST_WAIT  && cnt_q == 2'd1));

  arb2_rr u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       ({d_req, f_req}),
    .prio_mode_i (DATA_PRIO),
    .upd_i       (grant),
    .win_o       (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= 2'd0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      ram_csel_q  <= 1'b0;
      ram_read_q  <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      f_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      f_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      ram_csel_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q    <= win[1] ? OWN_DATA : OWN_FETCH;
            ram_addr_q <= win[1] ? d_addr : f_addr;
            ram_read_q <= win[1] ? ~d_we : 1'b1;
            if (win[1]) begin
              ram_wdata_q <= d_wdata;
            end
            ram_csel_q <= 1'b1;
            f_gnt_q    <= win[0];
            d_gnt_q    <= win[1];
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!ram_read_q) begin
            d_valid_q <= 1'b1;
            state_q   <= ST_RESP;
          end else if (RD_LAT == 1) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= 2'(RD_LAT - 1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= ST_RESP;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      if (rd_done) begin
        if (owner_q == OWN_DATA) begin
          d_rdata_q <= ram_rdata;
          d_valid_q <= 1'b1;
        end else begin
          f_rdata_q <= ram_rdata;
          f_valid_q <= 1'b1;
        end
      end
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_valid   = f_valid_q;
  assign d_valid   = d_valid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign ram_csel  = ram_csel_q;
  assign ram_read  = ram_read_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed bench for mem_port_arbiter across four latency/priority configurations
module tb_mem_port_arbiter;

  logic            clk;
  logic            rst;
  logic [3:0]      f_req, f_gnt, f_valid, d_req, d_we, d_gnt, d_valid;
  logic [3:0]      ram_csel, ram_read, busy;
  logic [3:0][7:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0][7:0] ram_addr, ram_wdata, ram_rdata;

  int          n_cmp;
  int          n_err;
  logic [63:0] got;
  logic [63:0] exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance 0: RD_LAT=1 data-prio, 1: RD_LAT=2 data-prio, 2: RD_LAT=1 round-robin, 3: RD_LAT=3 data-prio.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT  = (g == 1) ? 2 : (g == 3) ? 3 : 1;
    localparam bit PRIO = (g == 2) ? 1'b0 : 1'b1;

    logic [7:0]   mem_q [256];
    logic [255:0] wrt_q;
    logic [7:0]   rd0, p1_q, p2_q;

    // Unwritten locations read as addr^A5; EE marks bus cycles with no read data.
    always_comb begin
      rd0 = 8'hEE;
      if (ram_csel[g] && ram_read[g]) begin
        rd0 = wrt_q[ram_addr[g]] ? mem_q[ram_addr[g]] : (ram_addr[g] ^ 8'hA5);
      end
    end

    always @(posedge clk) begin
      p1_q <= rd0;
      p2_q <= p1_q;
      if (rst) begin
        wrt_q <= '0;
      end else if (ram_csel[g] && !ram_read[g]) begin
        mem_q[ram_addr[g]] <= ram_wdata[g];
        wrt_q[ram_addr[g]] <= 1'b1;
      end
    end

    assign ram_rdata[g] = (LAT == 1) ? rd0 : (LAT == 2) ? p1_q : p2_q;

    mem_port_arbiter #(
      .ADDR_W    (8),
      .DATA_W    (8),
      .RD_LAT    (LAT),
      .DATA_PRIO (PRIO)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .f_req     (f_req[g]),
      .f_addr    (f_addr[g]),
      .f_gnt     (f_gnt[g]),
      .f_valid   (f_valid[g]),
      .f_rdata   (f_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_valid   (d_valid[g]),
      .d_rdata   (d_rdata[g]),
      .ram_csel  (ram_csel[g]),
      .ram_read  (ram_read[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .busy      (busy[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_req = '0; d_req = '0; d_we = '0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      got = 64'({f_gnt[k], f_valid[k], f_rdata[k], d_gnt[k], d_valid[k], d_rdata[k],
                 ram_csel[k], ram_read[k], ram_addr[k], ram_wdata[k], busy[k]});
      n_cmp++;
      if (got !== 64'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", k, got);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch_only();
    f_addr[0] = 8'h10;
    f_req[0]  = 1'b1;
    step();
    got = 64'({f_gnt[0], ram_csel[0], ram_read[0], ram_addr[0], d_gnt[0], busy[0]});
    exp = 64'({1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL fetch_issue: got %h want %h", got, exp); end
    f_req[0] = 1'b0;
    step();
    got = 64'({f_valid[0], f_rdata[0], f_gnt[0], ram_csel[0], busy[0]});
    exp = 64'({1'b1, 8'hB5, 1'b0, 1'b0, 1'b1});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL fetch_valid: got %h want %h", got, exp); end
    step();
    got = 64'({busy[0], f_valid[0], f_rdata[0]});
    exp = 64'({1'b0, 1'b0, 8'hB5});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL fetch_idle: got %h want %h", got, exp); end
  endtask

  task automatic test_store_load();
    d_we[1] = 1'b1; d_addr[1] = 8'h20; d_wdata[1] = 8'h5C; d_req[1] = 1'b1;
    step();
    got = 64'({d_gnt[1], f_gnt[1], ram_csel[1], ram_read[1], ram_addr[1], ram_wdata[1]});
    exp = 64'({1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h5C});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL store_issue: got %h want %h", got, exp); end
    d_req[1] = 1'b0;
    step();
    got = 64'({d_valid[1], d_rdata[1], ram_csel[1], busy[1]});
    exp = 64'({1'b1, 8'h00, 1'b0, 1'b1});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL store_valid: got %h want %h", got, exp); end
    step();
    got = 64'({d_valid[1], busy[1]});
    n_cmp++;
    if (got !== 64'd0) begin n_err++; $display("FAIL store_idle: got %h want 0", got); end
    d_we[1] = 1'b0; d_wdata[1] = 8'h00; d_req[1] = 1'b1;
    step();
    got = 64'({d_gnt[1], ram_csel[1], ram_read[1], ram_addr[1], d_valid[1]});
    exp = 64'({1'b1, 1'b1, 1'b1, 8'h20, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL load_issue: got %h want %h", got, exp); end
    d_req[1] = 1'b0;
    step();
    got = 64'({d_valid[1], busy[1], ram_csel[1]});
    exp = 64'({1'b0, 1'b1, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL load_wait: got %h want %h", got, exp); end
    step();
    got = 64'({d_valid[1], d_rdata[1]});
    exp = 64'({1'b1, 8'h5C});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL load_valid: got %h want %h", got, exp); end
    step();
    got = 64'({d_valid[1], busy[1], d_rdata[1]});
    exp = 64'({1'b0, 1'b0, 8'h5C});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL load_hold: got %h want %h", got, exp); end
  endtask

  task automatic test_data_priority();
    f_addr[0] = 8'h30; d_addr[0] = 8'h40; d_we[0] = 1'b0;
    f_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      got = 64'({f_gnt[0], d_gnt[0]});
      exp = 64'({1'b0, (i % 3) == 0});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL prio_grant cycle %0d: got %h want %h", i, got, exp); end
    end
    d_req[0] = 1'b0;
    step();
    got = 64'({f_gnt[0], d_gnt[0], ram_addr[0]});
    exp = 64'({1'b1, 1'b0, 8'h30});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL prio_fetch_after: got %h want %h", got, exp); end
    f_req[0] = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_round_robin();
    f_addr[2] = 8'h31; d_addr[2] = 8'h41; d_we[2] = 1'b0;
    f_req[2] = 1'b1; d_req[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      got = 64'({f_gnt[2], d_gnt[2]});
      exp = 64'({((i % 3) == 0) && ((i / 3) % 2 == 0), ((i % 3) == 0) && ((i / 3) % 2 == 1)});
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL rr_grant cycle %0d: got %h want %h", i, got, exp); end
    end
    f_req[2] = 1'b0; d_req[2] = 1'b0;
    step();
    got = 64'({f_gnt[2], d_gnt[2], busy[2]});
    n_cmp++;
    if (got !== 64'd0) begin n_err++; $display("FAIL rr_drain: got %h want 0", got); end
  endtask

  task automatic test_reset_mid_read();
    f_addr[3] = 8'h55; f_req[3] = 1'b1;
    step();
    n_cmp++;
    if (f_gnt[3] !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt: got %b want 1", f_gnt[3]); end
    f_req[3] = 1'b0;
    step();
    got = 64'({busy[3], ram_csel[3], f_valid[3]});
    exp = 64'({1'b1, 1'b0, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstmid_wait: got %h want %h", got, exp); end
    rst = 1'b1;
    #1;
    got = 64'({ram_csel[3], f_valid[3], busy[3]});
    n_cmp++;
    if (got !== 64'd0) begin n_err++; $display("FAIL rstmid_async: got %h want 0", got); end
    step();
    step();
    got = 64'({f_valid[3], busy[3], f_rdata[3]});
    n_cmp++;
    if (got !== 64'd0) begin n_err++; $display("FAIL rstmid_hold: got %h want 0", got); end
    rst = 1'b0;
    f_addr[3] = 8'h66; f_req[3] = 1'b1;
    step();
    got = 64'({f_gnt[3], ram_csel[3], ram_addr[3], f_valid[3]});
    exp = 64'({1'b1, 1'b1, 8'h66, 1'b0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstmid_regrant: got %h want %h", got, exp); end
    f_req[3] = 1'b0;
    step();
    step();
    n_cmp++;
    if (f_valid[3] !== 1'b0) begin n_err++; $display("FAIL rstmid_early_valid: got %b want 0", f_valid[3]); end
    step();
    got = 64'({f_valid[3], f_rdata[3]});
    exp = 64'({1'b1, 8'hC3});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL rstmid_valid: got %h want %h", got, exp); end
    step();
    got = 64'({f_valid[3], busy[3]});
    n_cmp++;
    if (got !== 64'd0) begin n_err++; $display("FAIL rstmid_idle: got %h want 0", got); end
  endtask

  task automatic test_req_dropped();
    int         nv;
    int         ng;
    logic [7:0] rv;
    nv = 0; ng = 0; rv = 8'h00;
    f_addr[0] = 8'h77; f_req[0] = 1'b1;
    step();
    got = 64'({f_gnt[0], ram_addr[0]});
    exp = 64'({1'b1, 8'h77});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL drop_issue: got %h want %h", got, exp); end
    f_req[0] = 1'b0; f_addr[0] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      if (f_valid[0]) begin nv++; rv = f_rdata[0]; end
      if (f_gnt[0]) ng++;
    end
    got = 64'({nv[3:0], rv, ng[3:0]});
    exp = 64'({4'd1, 8'hD2, 4'd0});
    n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL drop_complete: got %h want %h", got, exp); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_data_priority();
    test_round_robin();
    test_reset_mid_read();
    test_req_dropped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
